// File: rtl/rom_reader_pkg.sv
// Shared types and constants for the ROM read sequencer: FSM state encoding,
// active levels of the ROM control pins and the default bus widths.
package rom_reader_pkg;

  localparam int ROM_ADDR_WIDTH = 9;
  localparam int ROM_DATA_WIDTH = 8;

  localparam logic ROM_CE_ACTIVE = 1'b0;
  localparam logic ROM_OE_ACTIVE = 1'b0;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    WAIT  = 3'd2,
    LATCH = 3'd3,
    HOLD  = 3'd4,
    DONE  = 3'd5
  } rom_state_e;

  // Chip is selected from address setup until the byte has been latched.
  function automatic logic ce_asserted(input rom_state_e s);
    return (s == SETUP) || (s == WAIT) || (s == LATCH);
  endfunction

  function automatic logic oe_asserted(input rom_state_e s);
    return (s == WAIT) || (s == LATCH);
  endfunction

endpackage

// File: rtl/rom_access_timer.sv
// Access-time down-counter: loaded with ACCESS_CYCLES as SETUP ends, counts
// while the sequencer waits, and flags the last WAIT cycle.
module rom_access_timer #(
  parameter int ACCESS_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic expired
);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = 4'(ACCESS_CYCLES);
    end else if (en && (cnt_q != 4'd0)) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  // NOTE: reset is synchronous and active-low; state updates use <= only.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == 4'd1);

endmodule

// File: rtl/rom_read_sequencer.sv
// Walks START_ADDR..END_ADDR of a parallel ROM with CE/OE timing and streams
// each byte out over valid/ready. Define ROM_READ_CHECKSUM_EN for the checksum.
module rom_read_sequencer
  import rom_reader_pkg::*;
#(
  parameter int ADDR_WIDTH    = ROM_ADDR_WIDTH,
  parameter int DATA_WIDTH    = ROM_DATA_WIDTH,
  parameter int ACCESS_CYCLES = 4,
  parameter int START_ADDR    = 0,
  parameter int END_ADDR      = (1 << ADDR_WIDTH) - 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  output logic                  rom_ce_n,
  output logic                  rom_oe_n,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] display_addr,
  output logic [15:0]           checksum
);

  localparam logic [ADDR_WIDTH-1:0] START_A = ADDR_WIDTH'(START_ADDR);
  localparam logic [ADDR_WIDTH-1:0] END_A   = ADDR_WIDTH'(END_ADDR);

  if (START_ADDR > END_ADDR) begin : g_bad_range
    $error("rom_read_sequencer: START_ADDR must not exceed END_ADDR");
  end
  if ((ACCESS_CYCLES < 1) || (ACCESS_CYCLES > 15)) begin : g_bad_access
    $error("rom_read_sequencer: ACCESS_CYCLES must be within 1..15");
  end

  rom_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  rom_ce_n_q, rom_oe_n_q, out_valid_q, busy_q, done_q;
  logic                  timer_expired;
  logic                  start_accept;
  logic                  byte_accept;

  assign start_accept = (state_q == IDLE) && start && !abort;
  assign byte_accept  = (state_q == HOLD) && out_ready;

  rom_access_timer #(
    .ACCESS_CYCLES(ACCESS_CYCLES)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (state_q == SETUP),
    .en     (state_q == WAIT),
    .expired(timer_expired)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    out_data_d = out_data_q;
    unique case (state_q)
      IDLE: begin
        if (start_accept) begin
          state_d = SETUP;
          addr_d  = START_A;
        end
      end
      SETUP: state_d = WAIT;
      WAIT:  if (timer_expired) state_d = LATCH;
      LATCH: begin
        state_d    = HOLD;
        out_data_d = rom_data;
      end
      HOLD: begin
        if (out_ready) begin
          if (addr_q == END_A) begin
            state_d = DONE;
          end else begin
            state_d = SETUP;
            addr_d  = addr_q + 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Abort overrides whatever the state wanted, including an increment.
    if (abort && (state_q != IDLE)) begin
      state_d    = IDLE;
      addr_d     = addr_q;
      out_data_d = out_data_q;
    end
  end

  // Pin-level outputs are decoded from the next state so they leave flops.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      addr_q      <= START_A;
      out_data_q  <= '0;
      rom_ce_n_q  <= ~ROM_CE_ACTIVE;
      rom_oe_n_q  <= ~ROM_OE_ACTIVE;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      out_data_q  <= out_data_d;
      rom_ce_n_q  <= ce_asserted(state_d) ? ROM_CE_ACTIVE : ~ROM_CE_ACTIVE;
      rom_oe_n_q  <= oe_asserted(state_d) ? ROM_OE_ACTIVE : ~ROM_OE_ACTIVE;
      out_valid_q <= (state_d == HOLD);
      busy_q      <= (state_d != IDLE);
      done_q      <= (state_d == DONE);
    end
  end

`ifdef ROM_READ_CHECKSUM_EN
  logic [15:0] checksum_q, checksum_d;

  always_comb begin
    checksum_d = checksum_q;
    if (start_accept) begin
      checksum_d = 16'd0;
    end else if (byte_accept) begin
      checksum_d = checksum_q + 16'(out_data_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      checksum_q <= 16'd0;
    end else begin
      checksum_q <= checksum_d;
    end
  end

  assign checksum = checksum_q;
`else
  logic unused_accept;
  assign unused_accept = byte_accept;
  assign checksum      = 16'd0;
`endif

  assign rom_addr     = addr_q;
  assign display_addr = addr_q;
  assign rom_ce_n     = rom_ce_n_q;
  assign rom_oe_n     = rom_oe_n_q;
  assign out_data     = out_data_q;
  assign out_valid    = out_valid_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_rom_read_sequencer.sv
// Self-checking bench for rom_read_sequencer: a default full-range instance and
// a single-byte instance, compared against a behavioural ROM/transfer model.
module tb_rom_read_sequencer;

  localparam int AC   = 4;
  localparam int AC_S = 1;
`ifdef ROM_READ_CHECKSUM_EN
  localparam bit CS_EN = 1'b1;
`else
  localparam bit CS_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, start, abort, out_ready;
  logic [8:0] rom_addr, display_addr;
  logic       rom_ce_n, rom_oe_n, out_valid, busy, done;
  logic [7:0] rom_data, out_data;
  logic [15:0] checksum;

  logic       start_s, abort_s, out_ready_s;
  logic [8:0] rom_addr_s, display_addr_s;
  logic       rom_ce_n_s, rom_oe_n_s, out_valid_s, busy_s, done_s;
  logic [7:0] rom_data_s, out_data_s;
  logic [15:0] checksum_s;

  logic [7:0] rom_tbl [512];
  logic       rom_mode;
  logic [15:0] cs_model;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // ROM socket model: mode 0 returns the low address byte, mode 1 a random table.
  function automatic logic [7:0] exp_byte(input logic [8:0] a);
    logic [7:0] lo;
    lo = a[7:0];
    return rom_mode ? rom_tbl[a] : lo;
  endfunction

  function automatic logic [15:0] exp_cs(input logic [15:0] m);
    return CS_EN ? m : 16'd0;
  endfunction

  always_comb rom_data   = exp_byte(rom_addr);
  always_comb rom_data_s = exp_byte(rom_addr_s);

  rom_read_sequencer #(.ACCESS_CYCLES(AC)) u_main (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .rom_addr(rom_addr), .rom_ce_n(rom_ce_n), .rom_oe_n(rom_oe_n),
    .rom_data(rom_data), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done),
    .display_addr(display_addr), .checksum(checksum)
  );

  rom_read_sequencer #(.ACCESS_CYCLES(AC_S), .START_ADDR(100), .END_ADDR(100)) u_single (
    .clk(clk), .reset(reset), .start(start_s), .abort(abort_s),
    .rom_addr(rom_addr_s), .rom_ce_n(rom_ce_n_s), .rom_oe_n(rom_oe_n_s),
    .rom_data(rom_data_s), .out_data(out_data_s), .out_valid(out_valid_s),
    .out_ready(out_ready_s), .busy(busy_s), .done(done_s),
    .display_addr(display_addr_s), .checksum(checksum_s)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check_idle_outputs(input string name);
    checks++;
    if ({rom_addr, rom_ce_n, rom_oe_n, out_data, out_valid, busy, done, display_addr, checksum}
        !== {9'd0, 1'b1, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0, 9'd0, 16'd0}) begin
      failures++;
      $display("FAIL %s main: addr=%0d ce_n=%b oe_n=%b data=%h valid=%b busy=%b done=%b disp=%0d cs=%h, need reset values",
               name, rom_addr, rom_ce_n, rom_oe_n, out_data, out_valid, busy, done, display_addr, checksum);
    end
    checks++;
    if ({rom_addr_s, rom_ce_n_s, rom_oe_n_s, out_data_s, out_valid_s, busy_s, done_s, checksum_s}
        !== {9'd100, 1'b1, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0, 16'd0}) begin
      failures++;
      $display("FAIL %s single: addr=%0d ce_n=%b oe_n=%b data=%h valid=%b busy=%b done=%b, need reset values",
               name, rom_addr_s, rom_ce_n_s, rom_oe_n_s, out_data_s, out_valid_s, busy_s, done_s);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    start_s = 1'b0; abort_s = 1'b0; out_ready_s = 1'b0;
    repeat (3) step();
    check_idle_outputs("reset");
    reset = 1'b1;
    step();
  endtask

  task automatic test_start_timing();
    rom_mode = 1'b1; out_ready = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    for (int c = 1; c <= AC + 4; c++) begin
      logic [3:0] want;
      want = {!(c >= 1 && c <= AC + 2), !(c >= 2 && c <= AC + 2), (c >= AC + 3), 1'b1};
      checks++;
      if ({rom_ce_n, rom_oe_n, out_valid, busy} !== want) begin
        failures++;
        $display("FAIL timing cycle %0d: ce_n/oe_n/valid/busy=%b need %b", c,
                 {rom_ce_n, rom_oe_n, out_valid, busy}, want);
      end
      if (c == AC + 3) begin
        checks++;
        if (out_data !== exp_byte(9'd0) || display_addr !== 9'd0) begin
          failures++;
          $display("FAIL first_byte: data=%h addr=%0d need %h at 0", out_data, display_addr, exp_byte(9'd0));
        end
      end
      step();
    end
    abort = 1'b1; step(); abort = 1'b0;
    checks++;
    if ({busy, out_valid, done} !== 3'b000) begin
      failures++;
      $display("FAIL abort_in_hold: busy/valid/done=%b need 000", {busy, out_valid, done});
    end
  endtask

  task automatic test_full_dump();
    int   idx = 0, done_cnt = 0;
    bit   finished = 0, prev_stall = 0, prev_last_hs = 0;
    logic [7:0] held = '0;
    rom_mode = 1'b0; cs_model = 16'd0; out_ready = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    for (int cyc = 0; cyc < 20000 && !finished; cyc++) begin
      if (done) begin
        done_cnt++;
        checks++;
        if (!prev_last_hs || checksum !== exp_cs(cs_model) || !busy) begin
          failures++;
          $display("FAIL dump_done: after_last=%b cs=%h need %h busy=%b", prev_last_hs, checksum,
                   exp_cs(cs_model), busy);
        end
        out_ready = 1'b0;
        step();
        checks++;
        if ({busy, done} !== 2'b00) begin
          failures++;
          $display("FAIL dump_end: busy/done=%b need 00", {busy, done});
        end
        finished = 1;
      end else begin
        if (prev_stall) begin
          checks++;
          if (!out_valid || out_data !== held) begin
            failures++;
            $display("FAIL dump_stall: valid=%b data=%h need 1 %h", out_valid, out_data, held);
          end
        end
        out_ready = ($urandom_range(3) != 0);
        prev_last_hs = 0;
        if (out_valid && out_ready) begin
          checks++;
          if (out_data !== exp_byte(9'(idx)) || display_addr !== 9'(idx) || !rom_ce_n) begin
            failures++;
            $display("FAIL dump_byte %0d: data=%h addr=%0d ce_n=%b need %h", idx, out_data,
                     display_addr, rom_ce_n, exp_byte(9'(idx)));
          end
          cs_model = cs_model + 16'(exp_byte(9'(idx)));
          prev_last_hs = (idx == 511);
          idx++;
        end
        prev_stall = out_valid && !out_ready;
        held = out_data;
        step();
      end
    end
    checks++;
    if (!finished || idx != 512 || done_cnt != 1) begin
      failures++;
      $display("FAIL dump_count: finished=%0d bytes=%0d dones=%0d need 1 512 1", finished, idx, done_cnt);
    end
    checks++;
    if (CS_EN && cs_model !== 16'hFF00) begin
      failures++;
      $display("FAIL dump_sum_model: %h need ff00", cs_model);
    end
  endtask

  task automatic test_backpressure();
    int  n;
    bit  found = 0;
    rom_mode = 1'b1; out_ready = 1'b1; cs_model = 16'd0;
    start = 1'b1; step(); start = 1'b0;
    for (int cyc = 0; cyc < 200 && !found; cyc++) begin
      if (out_valid && display_addr == 9'd5) begin
        found = 1;
        out_ready = 1'b0;
      end else begin
        if (out_valid) cs_model = cs_model + 16'(exp_byte(display_addr));
        step();
      end
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL bp_reach: address 5 never presented");
    end
    for (int c = 0; c < 10; c++) begin
      checks++;
      if ({out_valid, out_data, rom_ce_n, rom_addr} !== {1'b1, exp_byte(9'd5), 1'b1, 9'd5}) begin
        failures++;
        $display("FAIL bp_hold cycle %0d: valid=%b data=%h ce_n=%b addr=%0d need 1 %h 1 5", c,
                 out_valid, out_data, rom_ce_n, rom_addr, exp_byte(9'd5));
      end
      step();
    end
    out_ready = 1'b1;
    cs_model = cs_model + 16'(exp_byte(9'd5));
    step();
    out_ready = 1'b0;
    checks++;
    if ({rom_addr, rom_ce_n, rom_oe_n, out_valid} !== {9'd6, 1'b0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL bp_next: addr=%0d ce_n=%b oe_n=%b valid=%b need 6 0 1 0", rom_addr, rom_ce_n,
               rom_oe_n, out_valid);
    end
    n = 1;
    while (!out_valid && n < 50) begin
      step();
      n++;
    end
    checks++;
    if (n != AC + 3 || out_data !== exp_byte(9'd6) || checksum !== exp_cs(cs_model)) begin
      failures++;
      $display("FAIL bp_period: cycles=%0d data=%h cs=%h need %0d %h %h", n, out_data, checksum,
               AC + 3, exp_byte(9'd6), exp_cs(cs_model));
    end
    abort = 1'b1; step(); abort = 1'b0;
  endtask

  task automatic test_abort();
    bit found = 0;
    bit bad   = 0;
    rom_mode = 1'b1; out_ready = 1'b1; cs_model = 16'd0;
    start = 1'b1; step(); start = 1'b0;
    for (int cyc = 0; cyc < 200 && !found; cyc++) begin
      if (busy && rom_addr == 9'd3 && !rom_oe_n) begin
        found = 1;
      end else begin
        if (out_valid) cs_model = cs_model + 16'(exp_byte(display_addr));
        step();
      end
    end
    abort = 1'b1; step(); abort = 1'b0;
    checks++;
    if (!found || {busy, out_valid, rom_ce_n, rom_oe_n, done} !== 5'b00110
        || checksum !== exp_cs(cs_model)) begin
      failures++;
      $display("FAIL abort_wait: found=%0d busy/valid/ce_n/oe_n/done=%b cs=%h need 00110 %h", found,
               {busy, out_valid, rom_ce_n, rom_oe_n, done}, checksum, exp_cs(cs_model));
    end
    for (int c = 0; c < 4; c++) begin
      step();
      if (done || busy) bad = 1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL abort_quiet: done or busy seen after abort, need neither");
    end
    start = 1'b1; step(); start = 1'b0;
    checks++;
    if ({rom_addr, display_addr, rom_ce_n, checksum} !== {9'd0, 9'd0, 1'b0, 16'd0}) begin
      failures++;
      $display("FAIL abort_restart: addr=%0d disp=%0d ce_n=%b cs=%h need 0 0 0 0", rom_addr,
               display_addr, rom_ce_n, checksum);
    end
    out_ready = 1'b0;
    abort = 1'b1; step(); abort = 1'b0;
  endtask

  task automatic test_start_while_busy();
    int idx = 0;
    rom_mode = 1'b1; out_ready = 1'b1;
    start = 1'b1; step();
    for (int c = 1; c <= 40; c++) begin
      start = 1'($urandom_range(1));
      if (out_valid && out_ready) begin
        checks++;
        if (display_addr !== 9'(idx) || out_data !== exp_byte(9'(idx))) begin
          failures++;
          $display("FAIL busy_start byte %0d: addr=%0d data=%h need %0d %h", idx, display_addr,
                   out_data, idx, exp_byte(9'(idx)));
        end
        idx++;
      end
      step();
    end
    checks++;
    if (idx != 40 / (AC + 3)) begin
      failures++;
      $display("FAIL busy_start_rate: bytes=%0d need %0d", idx, 40 / (AC + 3));
    end
    out_ready = 1'b0;
    abort = 1'b1; start = 1'b1; step();
    checks++;
    if ({busy, out_valid} !== 2'b00) begin
      failures++;
      $display("FAIL abort_start_busy: busy/valid=%b need 00", {busy, out_valid});
    end
    step();
    abort = 1'b0; start = 1'b0;
    checks++;
    if ({busy, rom_ce_n} !== 2'b01) begin
      failures++;
      $display("FAIL abort_start_idle: busy/ce_n=%b need 01", {busy, rom_ce_n});
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    repeat (10) step();
    reset = 1'b0; step();
    check_idle_outputs("reset_mid");
    reset = 1'b1; out_ready = 1'b0;
    step();
  endtask

  task automatic test_single();
    int   hs = 0, done_cnt = 0;
    logic [15:0] cs = 16'd0;
    rom_mode = 1'b1;
    start_s = 1'b1; step(); start_s = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (done_s) done_cnt++;
      out_ready_s = 1'($urandom_range(1));
      if (out_valid_s && out_ready_s) begin
        hs++;
        cs = cs + 16'(exp_byte(9'd100));
        checks++;
        if (display_addr_s !== 9'd100 || out_data_s !== exp_byte(9'd100)) begin
          failures++;
          $display("FAIL single_byte: addr=%0d data=%h need 100 %h", display_addr_s, out_data_s,
                   exp_byte(9'd100));
        end
      end
      step();
    end
    checks++;
    if (hs != 1 || done_cnt != 1 || busy_s || checksum_s !== exp_cs(cs)) begin
      failures++;
      $display("FAIL single_summary: handshakes=%0d dones=%0d busy=%b cs=%h need 1 1 0 %h", hs,
               done_cnt, busy_s, checksum_s, exp_cs(cs));
    end
    out_ready_s = 1'b0;
  endtask

  initial begin
    rom_mode = 1'b1;
    cs_model = 16'd0;
    for (int i = 0; i < 512; i++) rom_tbl[i] = 8'($urandom);
    test_reset();
    test_start_timing();
    test_full_dump();
    test_backpressure();
    test_abort();
    test_start_while_busy();
    test_reset_mid();
    test_single();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rom_read_sequencer.md
# rom_read_sequencer

Sequencer that walks the ROM chip address space and reads each location with correct chip-enable/output-enable timing. It drives the ROM address pins, waits a programmable access time, latches the data byte and hands it to a downstream consumer (e.g. serial link) over a valid/ready handshake. It also exports the current address for the seven-segment address display and sits between the ROM socket pins and the transfer logic.

## Interface
- ADDR_WIDTH, 9: ROM address width.
- DATA_WIDTH, 8: ROM data width.
- ACCESS_CYCLES, 4: clk cycles `rom_oe_n` is held low before sampling; legal range 1..15.
- START_ADDR, 0: first address read.
- END_ADDR, 511: last address read; START_ADDR <= END_ADDR is required, and simulation `$error`s otherwise.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low.
- start  in  1  begin a dump; sampled only in IDLE.
- abort  in  1  terminate the dump; sampled in every non-IDLE state.
- rom_addr  out  ADDR_WIDTH  ROM address pins.
- rom_ce_n  out  1  chip enable, active-low.
- rom_oe_n  out  1  output enable, active-low.
- rom_data  in  DATA_WIDTH  ROM data pins.
- out_data  out  DATA_WIDTH  latched byte.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the END_ADDR byte is accepted.
- display_addr  out  ADDR_WIDTH  address of the byte most recently latched or in flight; feeds the display.
- checksum  out  16  see Configuration.

## Operation
- Reset values:
  - rom_addr = START_ADDR; display_addr = START_ADDR.
  - rom_ce_n = 1; rom_oe_n = 1.
  - out_data = 0; out_valid = 0; busy = 0; done = 0; checksum = 0.
  - State = IDLE.
- States:
  - IDLE: on start go to SETUP; address register loads START_ADDR.
  - SETUP: rom_ce_n = 0, rom_oe_n = 1, rom_addr stable. Lasts 1 cycle, then WAIT.
  - WAIT: rom_ce_n = 0, rom_oe_n = 0. Lasts ACCESS_CYCLES cycles, then LATCH.
  - LATCH: rom_ce_n = 0, rom_oe_n = 0. Lasts 1 cycle; rom_data is registered into out_data on the edge leaving LATCH, then HOLD.
  - HOLD: rom_ce_n = 1, rom_oe_n = 1, out_valid = 1. On out_valid & out_ready: if address == END_ADDR go to DONE, else increment the address and go to SETUP.
  - DONE: done = 1 for 1 cycle, then IDLE.
- Address is only ever incremented in HOLD, so it never wraps. START_ADDR == END_ADDR gives a single-byte dump.
- out_data holds its last value after the dump ends; out_valid deasserts on the edge following the handshake.
- start while busy: ignored.
- abort in any non-IDLE state: IDLE on the next edge. In that state rom_ce_n = rom_oe_n = 1, out_valid = 0, and done is not pulsed.
- abort coinciding with a handshake: the byte counts as accepted by the consumer, but the sequencer still goes to IDLE with no increment and no done pulse.
- abort has priority over start.
- reset low mid-dump: all outputs return to reset values on that edge.

## Timing
- start sampled in cycle 0:
  - SETUP in cycle 1.
  - WAIT in cycles 2..ACCESS_CYCLES+1.
  - LATCH in cycle ACCESS_CYCLES+2.
  - out_valid first high in cycle ACCESS_CYCLES+3 (cycle 7 at the default of 4).
- Per-byte period with out_ready held high: ACCESS_CYCLES+3 cycles (SETUP + WAIT + LATCH + 1 HOLD cycle).
- done is high in the cycle after the final handshake; busy is 0 in the cycle after that.
- All outputs are registered; no combinational path from out_ready or rom_data to any output.

## Configuration
- Macro: ROM_READ_CHECKSUM_EN.
- Defined:
  - checksum is a 16-bit modulo-2^16 sum of every accepted byte.
  - It clears to 0 on the cycle start is accepted and is stable while done is high.
  - An abort freezes its value.
- Undefined: checksum is tied to 0 and the accumulator is not instantiated.

## Structure
- Shared package rom_reader_pkg holds:
  - the state enum (IDLE, SETUP, WAIT, LATCH, HOLD, DONE);
  - constants ROM_CE_ACTIVE = 0 and ROM_OE_ACTIVE = 0;
  - the default ADDR_WIDTH and DATA_WIDTH.
- One sub-module, rom_access_timer: a 4-bit down-counter that is loaded with ACCESS_CYCLES on SETUP exit and signals expiry to leave WAIT.

## Test plan
- Reset/start: reset low 3 cycles, then start pulse, with defaults -> rom_ce_n falls in cycle 1, rom_oe_n falls in cycle 2, out_valid rises in cycle 7 with out_data equal to the ROM model's byte at address 0.
- Full dump: START_ADDR = 0, END_ADDR = 511, out_ready = 1, ROM model returns addr[7:0] -> 512 bytes 0x00..0xFF twice in order; one done pulse; with ROM_READ_CHECKSUM_EN, checksum = 0xFF00.
- Backpressure: out_ready low 10 cycles at address 5 -> out_valid and out_data held, rom_ce_n = 1, rom_addr stays 5; the next byte (address 6) starts after ready rises.
- Abort: abort asserted in the WAIT state of address 3 -> IDLE next cycle, busy = 0, out_valid = 0, no done pulse; a subsequent start restarts at address 0 with checksum cleared.
- Single byte: START_ADDR = END_ADDR = 100 -> exactly one handshake, display_addr = 100, done pulses once.
- Start while busy and abort with start: a start pulse mid-dump has no effect; abort and start asserted together -> IDLE.
